// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Converts a valid/ready command stream into APB3 transfers (one outstanding
// transfer) and returns read data / slave error on a one-deep valid/ready
// response buffer.
// Optional build macro: APB_TIMEOUT_EN -- bounds the ACCESS-phase wait to
// TIMEOUT_CYCLES wait cycles and terminates the transfer with an error.
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   // command channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response channel
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_slverr,
   // APB requester interface
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                  accept;
   logic                  xfer_done;
   logic                  timeout_hit;
   logic                  psel_nxt;
   logic                  penable_nxt;
   logic                  pwrite_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  rsp_slverr_nxt;

   // Reject an out-of-range wait limit at elaboration time.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be in 1..65535");
   end

   // A command is taken only in IDLE, out of reset, with room in the response buffer.
   assign cmd_ready = (state == IDLE) && PRESETn && (!rsp_valid || rsp_ready);
   assign accept    = cmd_valid && cmd_ready;

   // The slave completes only in a fully qualified ACCESS cycle.
   assign xfer_done = PSELx && PENABLE && PREADY;

`ifdef APB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] wait_cnt;

   // Wait counter: zero outside ACCESS, counts ACCESS cycles with PREADY low.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
      end else if (state != ACCESS) begin
         wait_cnt <= '0;
      end else if (!PREADY) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // A completing slave wins over the limit in the same cycle.
   assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == TIMEOUT_LIMIT);
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!PRESETn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-value logic for every registered output.
   always_comb begin
      // NOTE: every target gets a default before the case so no path leaves a
      // variable unassigned, which would infer a latch.
      state_nxt      = state;
      psel_nxt       = PSELx;
      penable_nxt    = PENABLE;
      pwrite_nxt     = PWRITE;
      paddr_nxt      = PADDR;
      pwdata_nxt     = PWDATA;
      rsp_valid_nxt  = rsp_valid && !rsp_ready;
      rsp_rdata_nxt  = rsp_rdata;
      rsp_slverr_nxt = rsp_slverr;

      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt  = SETUP;
               psel_nxt   = 1'b1;
               pwrite_nxt = cmd_write;
               paddr_nxt  = cmd_addr;
               pwdata_nxt = cmd_wdata;
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (xfer_done) begin
               state_nxt      = IDLE;
               psel_nxt       = 1'b0;
               penable_nxt    = 1'b0;
               rsp_valid_nxt  = 1'b1;
               rsp_rdata_nxt  = PWRITE ? '0 : PRDATA;
               rsp_slverr_nxt = PSLVERR;
            end else if (timeout_hit) begin
               state_nxt      = IDLE;
               psel_nxt       = 1'b0;
               penable_nxt    = 1'b0;
               rsp_valid_nxt  = 1'b1;
               rsp_rdata_nxt  = '0;
               rsp_slverr_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
   end

   // Registered APB and response outputs; reset aborts any transfer silently.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PSELx      <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_slverr <= 1'b0;
      end else begin
         PSELx      <= psel_nxt;
         PENABLE    <= penable_nxt;
         PWRITE     <= pwrite_nxt;
         PADDR      <= paddr_nxt;
         PWDATA     <= pwdata_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_rdata  <= rsp_rdata_nxt;
         rsp_slverr <= rsp_slverr_nxt;
      end
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that converts a simple valid/ready command stream into APB3 transfers toward the APB slave wrapper.
- Returns read data and error status on a one-deep buffered valid/ready response channel.
- Sits between the bus-agent/DPI command source and the slave's PSELx/PADDR/PWRITE/PWDATA/PENABLE inputs.
- Single outstanding transfer.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of the command/response data.
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit. Used only when APB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- PCLK  in  1  sole clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  out  1  PSLVERR sampled at completion (or timeout).
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE, all outputs 0 (PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_slverr). cmd_ready is 0 while reset is asserted.
- All APB outputs and response outputs are registered.
- cmd_ready is combinational: (state==IDLE) && PRESETn && (!rsp_valid || rsp_ready).
- States and transitions:
  - IDLE: on accept, capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, set PSELx=1, go SETUP.
  - SETUP: PSELx=1, PENABLE=0 for exactly one cycle, then PENABLE=1, go ACCESS.
  - ACCESS: hold PSELx=1, PENABLE=1, PADDR/PWRITE/PWDATA stable while PREADY=0. On the edge with PREADY=1:
    - register rsp_rdata = PWRITE ? 0 : PRDATA, rsp_slverr = PSLVERR, rsp_valid=1;
    - clear PSELx and PENABLE;
    - go IDLE.
- PADDR/PWRITE/PWDATA hold their last values in IDLE; PWDATA is don't-care for reads but still driven from capture.
- Latency, with acceptance at edge N: SETUP visible in cycle N+1, ACCESS in N+2. With zero wait states, rsp_valid rises in N+3. Each PREADY-low cycle adds one cycle.
- Back-to-back: a new command may be accepted in the first IDLE cycle, i.e. the same cycle rsp_valid is high, provided rsp_ready=1. Minimum spacing between SETUP phases is 3 cycles.
- Response buffer: rsp_valid stays high, data stable, until rsp_ready. rsp_valid clears on handshake unless a new response loads the same edge (impossible by construction, since at most one transfer is outstanding).
- Reset mid-transfer: immediate abort to IDLE with all outputs 0; no response generated.
- PSLVERR is sampled only when PSELx && PENABLE && PREADY.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entering ACCESS and increments every ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer terminates: PSELx/PENABLE drop next edge, rsp_valid=1, rsp_slverr=1, rsp_rdata=0, state IDLE.
  - PREADY=1 on the same cycle the limit is reached takes priority (normal completion).
- Undefined: no counter; ACCESS waits for PREADY indefinitely.

Test Plan:
- Write 0x0000_0004 <= 0xDEAD_BEEF, PREADY tied 1 -> PSELx high for cycles N+1..N+2, PENABLE only N+2, rsp_valid at N+3 with rsp_slverr=0, rsp_rdata=0.
- Read 0x0000_0004 after that write, slave returns 0xDEAD_BEEF with 3 wait states -> PADDR stable 5 cycles, PENABLE high 4 cycles, rsp_rdata=0xDEAD_BEEF.
- Read with PSLVERR=1 at completion -> rsp_slverr=1. A following write with PSLVERR=0 returns rsp_slverr=0.
- Response backpressure: rsp_ready=0 for 5 cycles while cmd_valid=1 -> cmd_ready=0, PSELx stays 0, response held stable. Raising rsp_ready accepts the next command in the same cycle.
- PRESETn pulsed low during ACCESS with PREADY=0 -> PSELx/PENABLE/rsp_valid go 0 asynchronously; after release, the next command runs normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> transfer aborts after 4 wait cycles, rsp_slverr=1, rsp_rdata=0. With PREADY=1 exactly at count 4 -> normal response with slave data.
